ifstage: RTL

IFSTAGE -- requirements
Module: ifstage

---
 rtl/ifstage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ifstage.sv
// ifstage: instruction fetch stage with IF/ID pipeline register.
//   Holds the fetch PC. Drives pc_o to instruction memory. Captures the
//   combinationally returned instruction into the IF/ID register.
//   The capture is governed by a small BOOT/RUN/HALTED/FAULT controller.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   pc_o                         fetch address (PC register)
//   instruction_i                memory word at pc_o, same cycle
//   stall_i                      decode not ready: hold PC and IF/ID
//   redirect_i/redirect_target_i taken branch/jump and its target
//   halt_i                       stop fetching (sticky until reset)
//   instr_o/pc_id_o/pc_plus4_id_o IF/ID register contents
//   valid_o                      IF/ID holds a real instruction
//   fault_o                      sticky misaligned-redirect flag
//   fetch_count_o                instructions accepted since reset
module ifstage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_o,
    input  logic [31:0] instruction_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        halt_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_id_o,
    output logic [31:0] pc_plus4_id_o,
    output logic        valid_o,
    output logic        fault_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pc_p4_q, pc_p4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    // Wraps modulo 2^32 by construction.
    logic [31:0] pc_plus4;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc_id_d = pc_id_q;
        pc_p4_d = pc_p4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;
        unique case (state_q)
            BOOT: begin
                valid_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    // Redirect wins over stall: the bubble replaces whatever
                    // decode was holding, since that instruction is squashed.
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (redirect_target_i[1:0] == 2'b00) begin
                        pc_d = redirect_target_i;
                    end else begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end else if (stall_i) begin
                    // Everything holds.
                end else if (halt_i) begin
                    // The IF/ID contents stay put on this edge. They are
                    // bubbled on the first edge in HALTED.
                    state_d = HALTED;
                end else begin
                    instr_d = instruction_i;
                    pc_id_d = pc_q;
                    pc_p4_d = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    count_d = count_q + 32'd1;
                end
            end
            HALTED, FAULT: begin
                // Terminal until reset. All fetch-side inputs are ignored.
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            instr_q <= NOP_INSTR;
            pc_id_q <= 32'd0;
            pc_p4_q <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc_id_q <= pc_id_d;
            pc_p4_q <= pc_p4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign pc_id_o       = pc_id_q;
    assign pc_plus4_id_o = pc_p4_q;
    assign valid_o       = valid_q;
    assign fault_o       = fault_q;
    assign fetch_count_o = count_q;

endmodule
